// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ byte-stream
// requesters. Round-robin selection; a grant is held for a whole message
// (through the req_last byte) or until the hold timer revokes it.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int HOLD_TIMEOUT = 1_000_000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 uart_tx_data,
  output logic                       uart_tx_start,
  input  logic                       uart_tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       grant_valid,
  output logic                       timeout_pulse
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int TW = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;
  // Timer value on which a held grant is revoked (unused when HOLD_TIMEOUT == 0).
  localparam logic [TW-1:0] TLIM = (HOLD_TIMEOUT > 0) ? TW'(HOLD_TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_HOLD
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      data_q,  data_d;
  logic            last_q,  last_d;
  logic [GW-1:0]   gid_q,   gid_d;
  logic [GW-1:0]   rr_q,    rr_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic            win_found;
  logic [GW-1:0]   win_idx;
  logic [NUM_REQ-1:0] ready_c;

  // Owner that follows id in round-robin order, wrapping to 0.
  function automatic logic [GW-1:0] next_id(input logic [GW-1:0] id);
    return (id == GW'(NUM_REQ - 1)) ? '0 : id + 1'b1;
  endfunction

  // Round-robin search: first valid requester at or above rr_q, with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && req_valid[(int'(rr_q) + k) % NUM_REQ]) begin
        win_found = 1'b1;
        win_idx   = GW'((int'(rr_q) + k) % NUM_REQ);
      end
    end
  end

  // Next-state logic, handshake and timeout; ready only offered in IDLE/HOLD.
  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    last_d        = last_q;
    gid_d         = gid_q;
    rr_d          = rr_q;
    timer_d       = timer_q;
    ready_c       = '0;
    timeout_pulse = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found && !uart_tx_busy) begin
          ready_c[win_idx] = 1'b1;
          data_d           = req_data[8*int'(win_idx) +: 8];
          last_d           = req_last[win_idx];
          gid_d            = win_idx;
          state_d          = S_START;
        end
      end
      S_START: begin
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (uart_tx_busy) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!uart_tx_busy) begin
          if (last_q) begin
            rr_d    = next_id(gid_q);
            state_d = S_IDLE;
          end else begin
            timer_d = '0;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        ready_c[gid_q] = !uart_tx_busy;
        // An accept takes precedence over a timeout landing in the same cycle.
        if (req_valid[gid_q] && !uart_tx_busy) begin
          data_d  = req_data[8*int'(gid_q) +: 8];
          last_d  = req_last[gid_q];
          state_d = S_START;
        end else if (HOLD_TIMEOUT != 0 && timer_q == TLIM) begin
          timeout_pulse = 1'b1;
          rr_d          = next_id(gid_q);
          state_d       = S_IDLE;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; everything clears on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      last_q  <= 1'b0;
      gid_q   <= '0;
      rr_q    <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      rr_q    <= rr_d;
      timer_q <= timer_d;
    end
  end

  // Ready is held low while reset is asserted so every output reads 0.
  assign req_ready     = reset_n ? ready_c : '0;
  assign uart_tx_data  = data_q;
  assign uart_tx_start = (state_q == S_START);
  assign grant_id      = gid_q;
  assign grant_valid   = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter; the bench plays the UART busy line.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int HOLD_TIMEOUT = 16;
  localparam int FRAME        = 4;

  logic                   clk;
  logic                   reset_n;
  logic [NUM_REQ-1:0]     req_valid;
  logic [8*NUM_REQ-1:0]   req_data;
  logic [NUM_REQ-1:0]     req_last;
  logic [NUM_REQ-1:0]     req_ready;
  logic [7:0]             uart_tx_data;
  logic                   uart_tx_start;
  logic                   uart_tx_busy;
  logic [1:0]             grant_id;
  logic                   grant_valid;
  logic                   timeout_pulse;

  int errors = 0;
  int checks = 0;

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .HOLD_TIMEOUT (HOLD_TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_start (uart_tx_start),
    .uart_tx_busy  (uart_tx_busy),
    .grant_id      (grant_id),
    .grant_valid   (grant_valid),
    .timeout_pulse (timeout_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int r, input logic v, input logic [7:0] d, input logic l);
    req_valid[r]        = v;
    req_data[8*r +: 8]  = d;
    req_last[r]         = l;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n      = 1'b0;
    req_valid    = '0;
    req_data     = '0;
    req_last     = '0;
    uart_tx_busy = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Wait (bounded) for a start pulse, then check the byte and owner.
  task automatic serve(input logic [7:0] exp_d, input logic [1:0] exp_g, input string tag);
    int n;
    n = 0;
    while (uart_tx_start !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_start"}, 32'(uart_tx_start), 32'(1'b1));
    chk({tag, "_data"},  32'(uart_tx_data),  32'(exp_d));
    chk({tag, "_gid"},   32'(grant_id),      32'(exp_g));
  endtask

  // UART frame: busy rises the cycle after start, stays high FRAME cycles.
  task automatic frame();
    @(negedge clk);
    uart_tx_busy = 1'b1;
    repeat (FRAME) @(negedge clk);
    uart_tx_busy = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int early;
    reset_n      = 1'b0;
    req_valid    = '0;
    req_data     = '0;
    req_last     = '0;
    uart_tx_busy = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'(req_ready),     32'(0));
    chk("rst_data",  32'(uart_tx_data),  32'(0));
    chk("rst_start", 32'(uart_tx_start), 32'(0));
    chk("rst_gid",   32'(grant_id),      32'(0));
    chk("rst_gv",    32'(grant_valid),   32'(0));
    chk("rst_tp",    32'(timeout_pulse), 32'(0));
    reset_n = 1'b1;

    // Test 1: req0 sends 0x41,0x42,0x43
    @(negedge clk);
    set_req(0, 1'b1, 8'h41, 1'b0);
    #1;
    chk("t1_ready", 32'(req_ready), 32'(4'b0001));
    serve(8'h41, 2'd0, "t1_b0");
    chk("t1_ready_start", 32'(req_ready), 32'(0));
    set_req(0, 1'b1, 8'h42, 1'b0);
    frame();
    serve(8'h42, 2'd0, "t1_b1");
    set_req(0, 1'b1, 8'h43, 1'b1);
    frame();
    serve(8'h43, 2'd0, "t1_b2");
    set_req(0, 1'b0, 8'h00, 1'b0);
    frame();
    #1;
    chk("t1_gv_busy_fall", 32'(grant_valid), 32'(1));
    @(negedge clk);
    chk("t1_gv_end", 32'(grant_valid), 32'(0));

    // Test 2: req0 and req2 together, 2-byte messages, no interleave
    do_reset();
    set_req(0, 1'b1, 8'h10, 1'b0);
    set_req(2, 1'b1, 8'h20, 1'b0);
    #1;
    chk("t2_ready_idle", 32'(req_ready), 32'(4'b0001));
    serve(8'h10, 2'd0, "t2_b0");
    set_req(0, 1'b1, 8'h11, 1'b1);
    frame();
    @(negedge clk);
    #1;
    chk("t2_hold_ready", 32'(req_ready), 32'(4'b0001));
    serve(8'h11, 2'd0, "t2_b1");
    set_req(0, 1'b0, 8'h00, 1'b0);
    frame();
    serve(8'h20, 2'd2, "t2_b2");
    set_req(2, 1'b1, 8'h21, 1'b1);
    frame();
    serve(8'h21, 2'd2, "t2_b3");
    set_req(2, 1'b0, 8'h00, 1'b0);
    frame();
    @(negedge clk);
    chk("t2_gv_end", 32'(grant_valid), 32'(0));

    // Test 3: all requesters continuously valid, single-byte messages
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 8'(8'h30 + i), 1'b1);
    for (int k = 0; k < 6; k++) begin
      serve(8'(8'h30 + k % 4), 2'(k % 4), $sformatf("t3_g%0d", k));
      frame();
    end
    req_valid = '0;
    @(negedge clk);

    // Test 4: req1 sends non-last byte then goes quiet; req2 waits
    do_reset();
    set_req(1, 1'b1, 8'h55, 1'b0);
    set_req(2, 1'b1, 8'h66, 1'b1);
    serve(8'h55, 2'd1, "t4_b0");
    set_req(1, 1'b0, 8'h00, 1'b0);
    frame();
    early = 0;
    for (int i = 1; i <= HOLD_TIMEOUT; i++) begin
      @(negedge clk);
      if (i < HOLD_TIMEOUT && timeout_pulse !== 1'b0) early++;
      if (i == 8) begin
        chk("t4_hold_ready", 32'(req_ready),   32'(4'b0010));
        chk("t4_hold_gv",    32'(grant_valid), 32'(1));
      end
    end
    chk("t4_no_early_pulse", 32'(early),         32'(0));
    chk("t4_pulse",          32'(timeout_pulse), 32'(1));
    @(negedge clk);
    chk("t4_pulse_clear", 32'(timeout_pulse), 32'(0));
    chk("t4_idle_gv",     32'(grant_valid),   32'(0));
    chk("t4_next_ready",  32'(req_ready),     32'(4'b0100));
    serve(8'h66, 2'd2, "t4_b1");
    set_req(2, 1'b0, 8'h00, 1'b0);
    frame();
    @(negedge clk);

    // Test 5: reset while in WAIT_DONE
    set_req(1, 1'b1, 8'h77, 1'b0);
    serve(8'h77, 2'd1, "t5_b0");
    set_req(1, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    uart_tx_busy = 1'b1;
    @(negedge clk);
    #1;
    chk("t5_gv_wait_done", 32'(grant_valid), 32'(1));
    set_req(3, 1'b1, 8'h99, 1'b1);
    reset_n      = 1'b0;
    uart_tx_busy = 1'b0;
    #1;
    chk("t5_rst_ready", 32'(req_ready),     32'(0));
    chk("t5_rst_data",  32'(uart_tx_data),  32'(0));
    chk("t5_rst_start", 32'(uart_tx_start), 32'(0));
    chk("t5_rst_gid",   32'(grant_id),      32'(0));
    chk("t5_rst_gv",    32'(grant_valid),   32'(0));
    chk("t5_rst_tp",    32'(timeout_pulse), 32'(0));
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("t5_ready_after", 32'(req_ready), 32'(4'b1000));
    serve(8'h99, 2'd3, "t5_b1");
    set_req(3, 1'b0, 8'h00, 1'b0);
    frame();
    @(negedge clk);

    // Test 6: busy held high in IDLE blocks the accept
    uart_tx_busy = 1'b1;
    set_req(0, 1'b1, 8'hAB, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("t6_ready_busy%0d", i), 32'(req_ready),   32'(0));
      chk($sformatf("t6_gv_busy%0d", i),    32'(grant_valid), 32'(0));
    end
    uart_tx_busy = 1'b0;
    #1;
    chk("t6_ready_free", 32'(req_ready), 32'(4'b0001));
    serve(8'hAB, 2'd0, "t6_b0");
    set_req(0, 1'b0, 8'h00, 1'b0);
    frame();
    @(negedge clk);
    chk("t6_gv_end", 32'(grant_valid), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
